// File: rtl/i2c_pkg.sv
// Shared types and protocol constants for the I2C responder.
//   slave_state_e : responder FSM states
//   I2C_ACK / I2C_NACK : value of SDA in the acknowledge bit
//   I2C_RW_READ : value of the R/W bit that selects a read
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } slave_state_e;

    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;
    localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Bus front end: brings SCL/SDA into the clk domain and derives bus events.
// Optional macro I2C_GLITCH_FILTER_EN adds a 3-sample stability filter after the synchronizers.
//   clk, rst      : system clock, synchronous active-high reset
//   scl, sda      : raw bus lines
//   sda_s         : conditioned SDA level
//   scl_rise_c    : 1-clk pulse on a conditioned SCL rising edge
//   scl_fall_c    : 1-clk pulse on a conditioned SCL falling edge
//   start_c       : 1-clk pulse on START (SDA falls while SCL high)
//   stop_c        : 1-clk pulse on STOP (SDA rises while SCL high)
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise_c,
    output logic scl_fall_c,
    output logic start_c,
    output logic stop_c
);

    logic [1:0] scl_ff;
    logic [1:0] sda_ff;
    logic       scl_f;
    logic       sda_f;
    logic       scl_p;
    logic       sda_p;

    // Two-stage synchronizers; reset to the idle (pulled-up) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_ff <= 2'b11;
            sda_ff <= 2'b11;
        end else begin
            scl_ff <= {scl_ff[0], scl};
            sda_ff <= {sda_ff[0], sda};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_h;
    logic [1:0] sda_h;

    // Output follows the line only once three consecutive samples agree.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_h <= 2'b11;
            sda_h <= 2'b11;
            scl_f <= 1'b1;
            sda_f <= 1'b1;
        end else begin
            scl_h <= {scl_h[0], scl_ff[1]};
            sda_h <= {sda_h[0], sda_ff[1]};
            if (scl_h == {2{scl_ff[1]}}) scl_f <= scl_ff[1];
            if (sda_h == {2{sda_ff[1]}}) sda_f <= sda_ff[1];
        end
    end
`else
    always_comb begin
        scl_f = scl_ff[1];
        sda_f = sda_ff[1];
    end
`endif

    // Previous conditioned levels for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_p <= scl_f;
            sda_p <= sda_f;
        end
    end

    assign sda_s      = sda_f;
    assign scl_rise_c = scl_f & ~scl_p;
    assign scl_fall_c = ~scl_f & scl_p;
    // SCL must be high on both samples so an SCL edge never counts as START/STOP.
    assign start_c    = scl_f & scl_p & sda_p & ~sda_f;
    assign stop_c     = scl_f & scl_p & ~sda_p & sda_f;

endmodule

// File: rtl/i2c_slave_memory.sv
// I2C responder with an internal byte memory addressed through a pointer.
// Write: S addr+W A ptr A data A ... P.  Read: S addr+R A data A ... NA P.
// Optional macro I2C_GLITCH_FILTER_EN enables the line glitch filter in i2c_bus_sync.
//   clk, rst : system clock, synchronous active-high reset
//   scl      : I2C clock (sampled only)
//   sda      : I2C data, open-drain (driven 0 or z)
//   busy     : high from an address match until STOP or the next address decode
//   done     : 1-clk pulse at the STOP ending an addressed transaction
//   ptrOut   : current memory pointer
module i2c_slave_memory
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h50,
    parameter int unsigned MEM_DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         scl,
    inout  wire                          sda,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(MEM_DEPTH)-1:0] ptrOut
);

    localparam int unsigned PTR_W = $clog2(MEM_DEPTH);

    slave_state_e     state;
    logic [2:0]       bitcnt;
    logic [6:0]       shreg;
    logic [7:0]       txbyte;
    logic             rw;
    logic             sda_oe;
    logic             rd_load;
    logic [PTR_W-1:0] ptr;
    logic [7:0]       mem [MEM_DEPTH];

    logic             sda_s;
    logic             scl_rise_c;
    logic             scl_fall_c;
    logic             start_c;
    logic             stop_c;
    logic [7:0]       rx_byte_c;

    i2c_bus_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .scl        (scl),
        .sda        (sda),
        .sda_s      (sda_s),
        .scl_rise_c (scl_rise_c),
        .scl_fall_c (scl_fall_c),
        .start_c    (start_c),
        .stop_c     (stop_c)
    );

    // Byte as it stands including the bit sampled on this SCL rise.
    assign rx_byte_c = {shreg, sda_s};
    assign sda       = sda_oe ? 1'b0 : 1'bz;
    assign ptrOut    = ptr;

    // Protocol FSM, shift register, pointer and memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bitcnt  <= '0;
            shreg   <= '0;
            txbyte  <= '0;
            rw      <= 1'b0;
            sda_oe  <= 1'b0;
            rd_load <= 1'b0;
            ptr     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'h00;
        end else begin
            done <= 1'b0;
            if (stop_c) begin
                state   <= IDLE;
                sda_oe  <= 1'b0;
                rd_load <= 1'b0;
                busy    <= 1'b0;
                done    <= busy;
            end else if (start_c) begin
                state   <= ADDR;
                sda_oe  <= 1'b0;
                rd_load <= 1'b0;
                bitcnt  <= '0;
            end else begin
                unique case (state)
                    IDLE: ;
                    ADDR: if (scl_rise_c) begin
                        shreg  <= rx_byte_c[6:0];
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            busy  <= (rx_byte_c[7:1] == SLAVE_ADDR);
                            rw    <= rx_byte_c[0];
                            state <= (rx_byte_c[7:1] == SLAVE_ADDR) ? ADDR_ACK : IDLE;
                        end
                    end
                    // First fall drives ACK; second fall ends it and starts the data phase.
                    ADDR_ACK: if (scl_fall_c) begin
                        bitcnt <= '0;
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else if (rw == I2C_RW_READ) begin
                            txbyte <= mem[ptr];
                            sda_oe <= ~mem[ptr][7];
                            state  <= RD_DATA;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= PTR;
                        end
                    end
                    PTR: if (scl_rise_c) begin
                        shreg  <= rx_byte_c[6:0];
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            ptr   <= rx_byte_c[PTR_W-1:0];
                            state <= PTR_ACK;
                        end
                    end
                    PTR_ACK, WR_ACK: if (scl_fall_c) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= WR_DATA;
                        end
                    end
                    WR_DATA: if (scl_rise_c) begin
                        shreg  <= rx_byte_c[6:0];
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            mem[ptr] <= rx_byte_c;
                            ptr      <= ptr + PTR_W'(1);
                            state    <= WR_ACK;
                        end
                    end
                    // bitcnt counts bits already clocked out; wraps to 0 after the 8th.
                    RD_DATA: begin
                        if (scl_rise_c) begin
                            bitcnt <= bitcnt + 3'd1;
                        end else if (scl_fall_c) begin
                            if (rd_load) begin
                                txbyte  <= mem[ptr];
                                sda_oe  <= ~mem[ptr][7];
                                rd_load <= 1'b0;
                            end else if (bitcnt == 3'd0) begin
                                sda_oe <= 1'b0;
                                state  <= RD_ACK;
                            end else begin
                                sda_oe <= ~txbyte[3'd7 - bitcnt];
                            end
                        end
                    end
                    RD_ACK: if (scl_rise_c) begin
                        ptr    <= ptr + PTR_W'(1);
                        bitcnt <= '0;
                        if (sda_s == I2C_ACK) begin
                            rd_load <= 1'b1;
                            state   <= RD_DATA;
                        end else begin
                            state <= WAIT_STOP;
                        end
                    end
                    WAIT_STOP: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_memory.sv
// Self-checking bench for i2c_slave_memory: a behavioural bus master drives
// directed and randomized transactions; a memory/pointer model predicts results.
module tb_i2c_slave_memory;

    localparam int Q = 10;  // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    wire        sda;
    logic       busy;
    logic       done;
    logic [3:0] ptr_out;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;

    logic [7:0] model_mem [16];
    logic [3:0] model_ptr;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    always #10 clk = ~clk;

    i2c_slave_memory #(.SLAVE_ADDR(7'h50), .MEM_DEPTH(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .scl    (scl),
        .sda    (sda),
        .busy   (busy),
        .done   (done),
        .ptrOut (ptr_out)
    );

    always @(negedge clk) if (done) done_cnt++;

    // ---------------- bus master primitives ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put_bit(input logic b);
        m_sda_low = ~b;
        tick(Q); scl = 1'b1; tick(2*Q); scl = 1'b0; tick(Q);
    endtask

    task automatic get_bit(output logic b);
        m_sda_low = 1'b0;
        tick(Q); scl = 1'b1; tick(Q); b = sda; tick(Q); scl = 1'b0; tick(Q);
    endtask

    task automatic send_start();
        m_sda_low = 1'b0;
        tick(Q); scl = 1'b1; tick(Q); m_sda_low = 1'b1; tick(Q); scl = 1'b0; tick(Q);
    endtask

    task automatic send_stop();
        m_sda_low = 1'b1;
        tick(Q); scl = 1'b1; tick(Q); m_sda_low = 1'b0; tick(2*Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(ack);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
        vectors++; if (ptr_out !== 4'h0) begin miscompares++; $display("FAIL reset_ptr: got %h expected 0", ptr_out); end
        vectors++; if (sda !== 1'b1) begin miscompares++; $display("FAIL reset_sda: got %b expected 1", sda); end
        rst = 1'b0;
        tick(4);
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        model_ptr = 4'h0;
    endtask

    task automatic test_write_basic();
        logic a;
        int   d0 = done_cnt;
        logic [7:0] bytes [4] = '{8'hA0, 8'h03, 8'hA5, 8'h3C};
        send_start();
        for (int i = 0; i < 4; i++) begin
            write_byte(bytes[i], a);
            vectors++; if (a !== 1'b0) begin miscompares++; $display("FAIL wr_ack[%0d]: got %b expected 0", i, a); end
            if (i == 0) begin
                vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL wr_busy: got %b expected 1", busy); end
            end
        end
        send_stop();
        model_mem[3] = 8'hA5; model_mem[4] = 8'h3C; model_ptr = 4'h5;
        vectors++; if (ptr_out !== model_ptr) begin miscompares++; $display("FAIL wr_ptr: got %h expected %h", ptr_out, model_ptr); end
        vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL wr_done: got %0d expected 1", done_cnt - d0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL wr_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_read_repstart();
        logic a;
        logic [7:0] d;
        int   d0 = done_cnt;
        send_start();
        write_byte(8'hA0, a);
        write_byte(8'h03, a);
        vectors++; if (a !== 1'b0) begin miscompares++; $display("FAIL rs_ptr_ack: got %b expected 0", a); end
        model_ptr = 4'h3;
        send_start();
        write_byte(8'hA1, a);
        vectors++; if (a !== 1'b0) begin miscompares++; $display("FAIL rs_addr_ack: got %b expected 0", a); end
        read_byte(1'b0, d);
        vectors++; if (d !== model_mem[model_ptr]) begin miscompares++; $display("FAIL rs_byte0: got %h expected %h", d, model_mem[model_ptr]); end
        model_ptr++;
        read_byte(1'b1, d);
        vectors++; if (d !== model_mem[model_ptr]) begin miscompares++; $display("FAIL rs_byte1: got %h expected %h", d, model_mem[model_ptr]); end
        model_ptr++;
        send_stop();
        vectors++; if (ptr_out !== model_ptr) begin miscompares++; $display("FAIL rs_ptr: got %h expected %h", ptr_out, model_ptr); end
        vectors++; if (sda !== 1'b1) begin miscompares++; $display("FAIL rs_sda: got %b expected 1", sda); end
        vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL rs_done: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_wrong_addr();
        logic a;
        int   d0 = done_cnt;
        send_start();
        write_byte(8'hA2, a);
        vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL wa_ack: got %b expected 1", a); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL wa_busy: got %b expected 0", busy); end
        send_stop();
        vectors++; if (done_cnt - d0 !== 0) begin miscompares++; $display("FAIL wa_done: got %0d expected 0", done_cnt - d0); end
        vectors++; if (ptr_out !== model_ptr) begin miscompares++; $display("FAIL wa_ptr: got %h expected %h", ptr_out, model_ptr); end
    endtask

    task automatic test_wrap();
        logic a;
        logic [7:0] d;
        send_start();
        write_byte(8'hA0, a); write_byte(8'h0F, a); write_byte(8'h11, a); write_byte(8'h22, a);
        vectors++; if (a !== 1'b0) begin miscompares++; $display("FAIL wrap_ack: got %b expected 0", a); end
        send_stop();
        model_mem[15] = 8'h11; model_mem[0] = 8'h22; model_ptr = 4'h1;
        vectors++; if (ptr_out !== model_ptr) begin miscompares++; $display("FAIL wrap_ptr: got %h expected %h", ptr_out, model_ptr); end
        send_start();
        write_byte(8'hA0, a); write_byte(8'hFF, a);  // upper pointer bits ignored
        model_ptr = 4'hF;
        send_start();
        write_byte(8'hA1, a);
        for (int i = 0; i < 2; i++) begin
            read_byte(i == 1, d);
            vectors++; if (d !== model_mem[model_ptr]) begin miscompares++; $display("FAIL wrap_rd[%0d]: got %h expected %h", i, d, model_mem[model_ptr]); end
            model_ptr++;
        end
        send_stop();
        vectors++; if (ptr_out !== model_ptr) begin miscompares++; $display("FAIL wrap_rd_ptr: got %h expected %h", ptr_out, model_ptr); end
    endtask

    task automatic test_stop_mid_byte();
        logic a;
        logic [7:0] d;
        send_start();
        write_byte(8'hA0, a); write_byte(8'h07, a);
        model_ptr = 4'h7;
        for (int i = 0; i < 4; i++) put_bit(1'b1);
        send_stop();
        vectors++; if (ptr_out !== model_ptr) begin miscompares++; $display("FAIL mid_ptr0: got %h expected %h", ptr_out, model_ptr); end
        send_start();
        write_byte(8'hA0, a);
        for (int i = 0; i < 5; i++) put_bit(1'b0);
        send_stop();
        vectors++; if (ptr_out !== model_ptr) begin miscompares++; $display("FAIL mid_ptr1: got %h expected %h", ptr_out, model_ptr); end
        send_start();
        write_byte(8'hA1, a);
        read_byte(1'b1, d);
        vectors++; if (d !== model_mem[model_ptr]) begin miscompares++; $display("FAIL mid_rd: got %h expected %h", d, model_mem[model_ptr]); end
        model_ptr++;
        send_stop();
    endtask

    task automatic test_random();
        logic a;
        logic [7:0] d;
        logic [7:0] p;
        int   d0;
        int   n;
        for (int it = 0; it < 14; it++) begin
            d0 = done_cnt;
            case ($urandom_range(0, 2))
                0: begin
                    p = 8'($urandom);
                    n = $urandom_range(0, 3);
                    send_start();
                    write_byte(8'hA0, a);
                    write_byte(p, a);
                    vectors++; if (a !== 1'b0) begin miscompares++; $display("FAIL rnd_ptr_ack[%0d]: got %b expected 0", it, a); end
                    model_ptr = p[3:0];
                    for (int k = 0; k < n; k++) begin
                        d = 8'($urandom);
                        write_byte(d, a);
                        vectors++; if (a !== 1'b0) begin miscompares++; $display("FAIL rnd_wr_ack[%0d]: got %b expected 0", it, a); end
                        model_mem[model_ptr] = d;
                        model_ptr++;
                    end
                    send_stop();
                    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL rnd_wr_done[%0d]: got %0d expected 1", it, done_cnt - d0); end
                end
                1: begin
                    n = $urandom_range(1, 3);
                    send_start();
                    write_byte(8'hA1, a);
                    for (int k = 0; k < n; k++) begin
                        read_byte(k == n - 1, d);
                        vectors++; if (d !== model_mem[model_ptr]) begin miscompares++; $display("FAIL rnd_rd[%0d]: got %h expected %h", it, d, model_mem[model_ptr]); end
                        model_ptr++;
                    end
                    send_stop();
                    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL rnd_rd_done[%0d]: got %0d expected 1", it, done_cnt - d0); end
                end
                default: begin
                    p = 8'($urandom);
                    if (p[7:1] == 7'h50) p[7:1] = 7'h2A;
                    send_start();
                    write_byte(p, a);
                    vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL rnd_wa_ack[%0d]: got %b expected 1", it, a); end
                    send_stop();
                    vectors++; if (done_cnt - d0 !== 0) begin miscompares++; $display("FAIL rnd_wa_done[%0d]: got %0d expected 0", it, done_cnt - d0); end
                end
            endcase
            vectors++; if (ptr_out !== model_ptr) begin miscompares++; $display("FAIL rnd_ptr[%0d]: got %h expected %h", it, ptr_out, model_ptr); end
        end
    endtask

    task automatic test_reset_mid_read();
        logic a;
        logic b;
        logic [7:0] d;
        send_start();
        write_byte(8'hA0, a); write_byte(8'h02, a); write_byte(8'h0F, a);
        send_start();
        write_byte(8'hA0, a); write_byte(8'h02, a);
        send_start();
        write_byte(8'hA1, a);
        for (int i = 0; i < 3; i++) get_bit(b);
        m_sda_low = 1'b0;
        tick(Q); scl = 1'b1; tick(Q);
        vectors++; if (sda !== 1'b0) begin miscompares++; $display("FAIL rr_bit3: got %b expected 0", sda); end
        rst = 1'b1;
        tick(1);
        vectors++; if (sda !== 1'b1) begin miscompares++; $display("FAIL rr_sda: got %b expected 1", sda); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rr_busy: got %b expected 0", busy); end
        vectors++; if (ptr_out !== 4'h0) begin miscompares++; $display("FAIL rr_ptr: got %h expected 0", ptr_out); end
        scl = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(Q);
        send_stop();
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        model_ptr = 4'h0;
        send_start();
        write_byte(8'hA0, a); write_byte(8'h02, a);
        model_ptr = 4'h2;
        send_start();
        write_byte(8'hA1, a);
        read_byte(1'b1, d);
        vectors++; if (d !== model_mem[model_ptr]) begin miscompares++; $display("FAIL rr_cleared: got %h expected %h", d, model_mem[model_ptr]); end
        model_ptr++;
        send_stop();
        vectors++; if (ptr_out !== model_ptr) begin miscompares++; $display("FAIL rr_ptr_end: got %h expected %h", ptr_out, model_ptr); end
    endtask

`ifdef I2C_GLITCH_FILTER_EN
    task automatic test_glitch();
        logic a;
        int   d0 = done_cnt;
        m_sda_low = 1'b1;
        tick(2);
        m_sda_low = 1'b0;
        tick(Q);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL gl_busy: got %b expected 0", busy); end
        vectors++; if (done_cnt - d0 !== 0) begin miscompares++; $display("FAIL gl_done: got %0d expected 0", done_cnt - d0); end
        send_start();
        write_byte(8'hA0, a);
        vectors++; if (a !== 1'b0) begin miscompares++; $display("FAIL gl_ack: got %b expected 0", a); end
        write_byte(8'h09, a); write_byte(8'h5A, a);
        vectors++; if (a !== 1'b0) begin miscompares++; $display("FAIL gl_data_ack: got %b expected 0", a); end
        send_stop();
        model_mem[9] = 8'h5A; model_ptr = 4'hA;
        vectors++; if (ptr_out !== model_ptr) begin miscompares++; $display("FAIL gl_ptr: got %h expected %h", ptr_out, model_ptr); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_basic();
        test_read_repstart();
        test_wrong_addr();
        test_wrap();
        test_stop_mid_byte();
        test_random();
        test_reset_mid_read();
`ifdef I2C_GLITCH_FILTER_EN
        test_glitch();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
